// File: rtl/vga_pattern_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// vga_seq_pkg
// Shared definitions for the VGA pattern sequencer:
//   - mode_e       : 2-bit pattern mode encoding (SOLID, BARS, CHECKER, CYCLE)
//   - BLACK        : colour driven outside the visible region
//   - nextMode()   : mode advance order, wrapping CYCLE back to SOLID
//   - barColour()  : maps a 3-bit colour-bar index to a 12-bit RGB value
// No ports; imported by the sequencer top.
// ----------------------------------------------------------------------------
package vga_seq_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID   = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_CYCLE   = 2'd3
  } mode_e;

  localparam logic [11:0] BLACK = 12'h000;

  // Modes are visited in encoding order; the last one wraps to the first.
  function automatic mode_e nextMode(input mode_e current);
    case (current)
      MODE_SOLID:   return MODE_BARS;
      MODE_BARS:    return MODE_CHECKER;
      MODE_CHECKER: return MODE_CYCLE;
      default:      return MODE_SOLID;
    endcase
  endfunction

  // Each bar index bit switches one colour channel fully on or off, giving
  // the classic eight-bar sequence black, blue, green, cyan, red, ... white.
  function automatic logic [11:0] barColour(input logic [2:0] barIndex);
    return {{4{barIndex[2]}}, {4{barIndex[1]}}, {4{barIndex[0]}}};
  endfunction

endpackage

// File: rtl/vga_pattern_sequencer_btn_sync_edge.sv
// ----------------------------------------------------------------------------
// btn_sync_edge
// Brings an asynchronous push-button into the clock domain with a two-flop
// synchroniser and produces a single-cycle pulse on each rising edge.
// Reusable for any board button.
// Ports:
//   clk      - system clock
//   reset    - asynchronous, active-high reset
//   btn_i    - raw asynchronous button level
//   pulse_o  - one-cycle pulse per synchronised rising edge
// ----------------------------------------------------------------------------
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);

  logic syncMeta_q;
  logic syncOut_q;
  logic syncPrev_q;

  // Two synchroniser stages followed by one history flop for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      syncMeta_q <= 1'b0;
      syncOut_q  <= 1'b0;
      syncPrev_q <= 1'b0;
    end else begin
      syncMeta_q <= btn_i;
      syncOut_q  <= syncMeta_q;
      syncPrev_q <= syncOut_q;
    end
  end

  // Only the synchronised level is compared, never the metastable stage.
  assign pulse_o = syncOut_q & ~syncPrev_q;

endmodule

// File: rtl/vga_pattern_sequencer.sv
// ----------------------------------------------------------------------------
// vga_pattern_sequencer
// Frame-synchronous test-pattern generator placed between vga_sync and the
// board RGB pins. Mode changes and switch-colour captures happen only at frame
// boundaries, so a frame never shows a mix of two patterns. The pixel colour
// is registered and the syncs are delayed by one cycle to stay aligned.
// Ports:
//   clk, reset        - system clock, asynchronous active-high reset
//   sw[11:0]          - user colour {R,G,B}, captured at frame boundaries
//   btn_next          - asynchronous button, each press requests next mode
//   hsync_in,vsync_in - retrace pulses from vga_sync (active high)
//   video_on          - visible-region flag
//   pixel_x, pixel_y  - current pixel coordinates
//   hsync, vsync      - syncs delayed one cycle
//   rgb[11:0]         - registered pixel colour
//   mode[1:0]         - current pattern mode
//   frame_tick        - one-cycle pulse at each frame boundary
// ----------------------------------------------------------------------------
module vga_pattern_sequencer
  import vga_seq_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 30,
  parameter int CHECK_BIT       = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] sw,
  input  logic        btn_next,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        video_on,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic [1:0]  mode,
  output logic        frame_tick
);

  localparam logic [7:0] STEP_LAST = 8'(FRAMES_PER_STEP - 1);

  mode_e       mode_q, mode_d;
  logic [11:0] colourReg_q, colourReg_d;
  logic [11:0] cycleColour_q, cycleColour_d;
  logic [7:0]  frameCnt_q, frameCnt_d;
  logic        pending_q, pending_d;

  logic        hsync_q;
  logic        vsync_q;
  logic        frameTick_q;
  logic [11:0] rgb_q;

  logic        btnPulse;
  logic        advance;
  logic [11:0] pattern;
  logic        unusedPixelBits;

  btn_sync_edge u_btnNext (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (btn_next),
    .pulse_o (btnPulse)
  );

  // Frame state register: everything that may only change on a frame tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q        <= MODE_SOLID;
      colourReg_q   <= BLACK;
      cycleColour_q <= BLACK;
      frameCnt_q    <= 8'd0;
      pending_q     <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      colourReg_q   <= colourReg_d;
      cycleColour_q <= cycleColour_d;
      frameCnt_q    <= frameCnt_d;
      pending_q     <= pending_d;
    end
  end

  // A press coinciding with the boundary is consumed there, so the pending
  // flag is only set by presses arriving between boundaries. Any number of
  // presses in one frame collapse into a single advance.
  assign advance = frameTick_q & (pending_q | btnPulse);

  // Next-state logic for mode, captured colour and the CYCLE colour stepper.
  always_comb begin
    mode_d        = mode_q;
    colourReg_d   = colourReg_q;
    cycleColour_d = cycleColour_q;
    frameCnt_d    = frameCnt_q;
    pending_d     = pending_q;

    if (frameTick_q) begin
      colourReg_d = sw;

      if (mode_q == MODE_CYCLE) begin
        if (frameCnt_q == STEP_LAST) begin
          frameCnt_d    = 8'd0;
          cycleColour_d = cycleColour_q + 12'd1;
        end else begin
          frameCnt_d = frameCnt_q + 8'd1;
        end
      end

      if (advance) begin
        mode_d    = nextMode(mode_q);
        pending_d = 1'b0;
        // Entering CYCLE restarts the stepper from the current switches.
        if (mode_q == MODE_CHECKER) begin
          frameCnt_d    = 8'd0;
          cycleColour_d = sw;
        end
      end
    end else if (btnPulse) begin
      pending_d = 1'b1;
    end
  end

  // Pattern mux, evaluated from this cycle's pixel coordinates.
  always_comb begin
    pattern = BLACK;
    case (mode_q)
      MODE_SOLID:   pattern = colourReg_q;
      MODE_BARS:    pattern = barColour(pixel_x[8:6]);
      MODE_CHECKER: pattern = (pixel_x[CHECK_BIT] ^ pixel_y[CHECK_BIT])
                              ? ~colourReg_q : colourReg_q;
      MODE_CYCLE:   pattern = cycleColour_q;
      default:      pattern = BLACK;
    endcase
  end

  // Output stage and frame-boundary detector. The delayed vsync doubles as
  // the history bit for the rising-edge detector, so frame_tick lands one
  // cycle after vsync_in rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q       <= BLACK;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      frameTick_q <= 1'b0;
    end else begin
      rgb_q       <= video_on ? pattern : BLACK;
      hsync_q     <= hsync_in;
      vsync_q     <= vsync_in;
      frameTick_q <= vsync_in & ~vsync_q;
    end
  end

  // Only a few coordinate bits steer the patterns.
  assign unusedPixelBits = ^{pixel_x, pixel_y};

  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign rgb        = rgb_q;
  assign mode       = mode_q;
  assign frame_tick = frameTick_q;

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// ----------------------------------------------------------------------------
// tb_vga_pattern_sequencer
// Directed scenarios with literal expectations followed by a randomized run.
// A behavioural model of the frame rules runs alongside and every cycle's
// outputs are compared against it.
// ----------------------------------------------------------------------------
module tb_vga_pattern_sequencer;

  localparam int FPS = 2;
  localparam int CB  = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] sw = 12'h000;
  logic        btn_next = 1'b0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic        video_on = 1'b0;
  logic [9:0]  pixel_x = 10'd0;
  logic [9:0]  pixel_y = 10'd0;
  logic        hsync;
  logic        vsync;
  logic [11:0] rgb;
  logic [1:0]  mode;
  logic        frame_tick;

  int vectorCount = 0;
  int miscompareCount = 0;

  // Model state: plain integers tracking what the outputs must be.
  int mMode, mColour, mCyc, mCnt, mRgb;
  bit mPend, mTick, mHs, mVs;
  bit bh [3];
  int btnHold = 0;

  vga_pattern_sequencer #(
    .FRAMES_PER_STEP (FPS),
    .CHECK_BIT       (CB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sw         (sw),
    .btn_next   (btn_next),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .video_on   (video_on),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .hsync      (hsync),
    .vsync      (vsync),
    .rgb        (rgb),
    .mode       (mode),
    .frame_tick (frame_tick)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // One comparison: counts it and reports any difference.
  task automatic checkVal(input string name, input int actual, input int expected);
    vectorCount++;
    if (actual != expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Everything returns to power-on values.
  task automatic modelReset();
    mMode = 0; mColour = 0; mCyc = 0; mCnt = 0; mRgb = 0;
    mPend = 0; mTick = 0; mHs = 0; mVs = 0;
    bh[0] = 0; bh[1] = 0; bh[2] = 0;
  endtask

  // Colour the current mode paints at the current pixel.
  function automatic int patternOf();
    int i;
    case (mMode)
      0: return mColour;
      1: begin
        i = (int'(pixel_x) / 64) % 8;
        return ((i & 4) != 0 ? 'hF00 : 0) | ((i & 2) != 0 ? 'h0F0 : 0) | ((i & 1) != 0 ? 'h00F : 0);
      end
      2: return ((((int'(pixel_x) >> CB) ^ (int'(pixel_y) >> CB)) & 1) != 0) ? (~mColour & 'hFFF) : mColour;
      default: return mCyc;
    endcase
  endfunction

  // Colour stepper in CYCLE mode: advance once every FPS frames.
  task automatic stepCycle();
    if (mCnt == FPS - 1) begin
      mCnt = 0;
      mCyc = (mCyc + 1) % 4096;
    end else begin
      mCnt = (mCnt + 1) % 256;
    end
  endtask

  // Effect of one clock edge. A button pulse appears two samples after the
  // button rises; the frame boundary is the previous edge's vsync rise.
  task automatic modelStep();
    bit pulse;
    pulse = bh[1] & ~bh[2];
    mRgb = video_on ? patternOf() : 0;
    if (mTick) begin
      if (mMode == 3) stepCycle();
      if (mPend || pulse) begin
        if (mMode == 2) begin
          mCnt = 0;
          mCyc = int'(sw);
        end
        mMode = (mMode + 1) % 4;
        mPend = 0;
      end
      mColour = int'(sw);
    end else if (pulse) begin
      mPend = 1;
    end
    mTick = vsync_in & ~mVs;
    mVs = vsync_in;
    mHs = hsync_in;
    bh[2] = bh[1]; bh[1] = bh[0]; bh[0] = btn_next;
  endtask

  // Compare every output against the model.
  task automatic checkOutput();
    checkVal("rgb", int'(rgb), mRgb);
    checkVal("mode", int'(mode), mMode);
    checkVal("frame_tick", int'(frame_tick), int'(mTick));
    checkVal("hsync", int'(hsync), int'(mHs));
    checkVal("vsync", int'(vsync), int'(mVs));
  endtask

  // One clock: model follows the edge, outputs checked on the falling edge.
  task automatic step();
    @(posedge clk);
    if (reset) modelReset();
    else modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  // A vsync pulse followed by enough cycles for the new state to reach rgb.
  task automatic doFrame();
    vsync_in = 1'b1; step(); step();
    vsync_in = 1'b0; step(); step();
  endtask

  task automatic pressBtn();
    btn_next = 1'b1; step(); step(); step();
    btn_next = 1'b0; step(); step(); step();
  endtask

  // Random inputs with a regular frame cadence and held button presses.
  task automatic applyStimulus(input int cyc);
    vsync_in = (cyc % 47) < 3;
    hsync_in = (cyc % 9) < 2;
    video_on = $urandom_range(0, 3) != 0;
    pixel_x = 10'($urandom_range(0, 639));
    pixel_y = 10'($urandom_range(0, 479));
    if ($urandom_range(0, 7) == 0) sw = 12'($urandom);
    if (btnHold == 0) begin
      btn_next = 1'($urandom_range(0, 1));
      btnHold = $urandom_range(1, 30);
    end else begin
      btnHold--;
    end
  endtask

  // Main sequence: directed scenarios, then randomized traffic.
  initial begin
    modelReset();
    #1 reset = 1'b1;
    #1;
    checkVal("reset_rgb", int'(rgb), 0);
    checkVal("reset_mode", int'(mode), 0);
    checkVal("reset_tick", int'(frame_tick), 0);
    step(); step();
    reset = 1'b0;

    // Solid colour captured at a frame boundary.
    sw = 12'hF00; video_on = 1'b1;
    step(); step();
    vsync_in = 1'b1; step();
    checkVal("tick_high", int'(frame_tick), 1);
    step();
    checkVal("tick_one_cycle", int'(frame_tick), 0);
    vsync_in = 1'b0; step(); step();
    checkVal("solid_F00", int'(rgb), 'hF00);
    video_on = 1'b0; step();
    checkVal("blank_black", int'(rgb), 0);
    video_on = 1'b1;

    // Switch change mid-frame waits for the boundary.
    sw = 12'h0F0; step(); step();
    checkVal("hold_F00", int'(rgb), 'hF00);
    doFrame();
    checkVal("solid_0F0", int'(rgb), 'h0F0);

    // Three presses in one frame give a single advance into BARS.
    pressBtn(); pressBtn(); pressBtn();
    checkVal("mode_waits", int'(mode), 0);
    doFrame();
    checkVal("mode_bars", int'(mode), 1);
    pixel_x = 10'd0;   step(); checkVal("bar_x0", int'(rgb), 'h000);
    pixel_x = 10'd64;  step(); checkVal("bar_x64", int'(rgb), 'h00F);
    pixel_x = 10'd448; step(); checkVal("bar_x448", int'(rgb), 'hFFF);
    pixel_x = 10'd512; step(); checkVal("bar_x512", int'(rgb), 'h000);
    doFrame();
    checkVal("single_advance", int'(mode), 1);

    // Button pulse lands on the same edge as the frame tick.
    btn_next = 1'b1; step();
    vsync_in = 1'b1; step();
    step();
    checkVal("coincident_adv", int'(mode), 2);
    vsync_in = 1'b0; btn_next = 1'b0; step(); step();
    doFrame();
    checkVal("no_second_adv", int'(mode), 2);

    // Checker squares against the captured colour.
    sw = 12'h123; doFrame();
    pixel_x = 10'd0;  pixel_y = 10'd0;  step(); checkVal("chk_00", int'(rgb), 'h123);
    pixel_x = 10'd32; pixel_y = 10'd0;  step(); checkVal("chk_32_0", int'(rgb), 'hEDC);
    pixel_x = 10'd32; pixel_y = 10'd32; step(); checkVal("chk_32_32", int'(rgb), 'h123);

    // CYCLE entry from FFE, stepping every two frames through the wrap.
    sw = 12'hFFE; pressBtn(); doFrame();
    checkVal("cycle_mode", int'(mode), 3);
    checkVal("cycle_FFE_a", int'(rgb), 'hFFE);
    sw = 12'hABC;
    doFrame(); checkVal("cycle_FFE_b", int'(rgb), 'hFFE);
    doFrame(); checkVal("cycle_FFF_a", int'(rgb), 'hFFF);
    doFrame(); checkVal("cycle_FFF_b", int'(rgb), 'hFFF);
    doFrame(); checkVal("cycle_000", int'(rgb), 'h000);

    // Asynchronous reset in the middle of a frame.
    hsync_in = 1'b1; vsync_in = 1'b1; step();
    reset = 1'b1;
    #1;
    checkVal("async_rgb", int'(rgb), 0);
    checkVal("async_mode", int'(mode), 0);
    checkVal("async_hsync", int'(hsync), 0);
    checkVal("async_vsync", int'(vsync), 0);
    modelReset();
    step();
    hsync_in = 1'b0; vsync_in = 1'b0; reset = 1'b0;
    step();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(c);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule
